// File: rtl/code_entry_pkg.sv
// Shared constants, state encoding and width helper for the code entry sequencer.
package code_entry_pkg;

    localparam int unsigned DIGIT_W_DEF     = 4;
    localparam int unsigned TIMEOUT_CYC_DEF = 50_000_000;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_COLLECT = 2'b01;
    localparam logic [1:0] ST_PRESENT = 2'b10;

    function automatic int unsigned cnt_width(input int unsigned digits);
        return $clog2(digits + 1);
    endfunction

endpackage

// File: rtl/entry_timeout_timer.sv
// Inactivity counter: flags expiry after TIMEOUT_CYC consecutive run cycles without a restart.
module entry_timeout_timer #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic run,
    input  logic restart,
    output logic expired
);

    localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TW-1:0] r_cnt;

    assign expired = run && (r_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (restart || !run || expired) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/code_entry_sequencer.sv
// Collects DIGITS switch digits into one code word with a one-cycle valid strobe.
// Optional inactivity timeout enabled by defining CODE_ENTRY_TIMEOUT_EN.
module code_entry_sequencer
    import code_entry_pkg::*;
#(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned DIGIT_W     = DIGIT_W_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [DIGIT_W-1:0]            digit_in,
    input  logic                          enter_pulse,
    input  logic                          clear_pulse,
    output logic [DIGITS*DIGIT_W-1:0]     code_out,
    output logic                          code_valid,
    output logic [cnt_width(DIGITS)-1:0]  digit_count,
    output logic                          busy,
    output logic                          timeout_err
);

    localparam int unsigned BW = DIGITS * DIGIT_W;
    localparam int unsigned CW = cnt_width(DIGITS);

    if (DIGITS < 1 || DIGITS > 8 || TIMEOUT_CYC < 2) begin : g_param_check
        $error("code_entry_sequencer: DIGITS must be 1..8 and TIMEOUT_CYC >= 2");
    end

    logic [1:0]    r_state;
    logic [BW-1:0] r_buf;
    logic [CW-1:0] r_cnt;
    logic [BW-1:0] r_code;
    logic          r_valid;
    logic          r_busy;
    logic          r_tout;

    logic [1:0]    w_state_n;
    logic [BW-1:0] w_buf_n;
    logic [CW-1:0] w_cnt_n;
    logic [CW-1:0] w_cnt_inc;
    logic          w_load;
    logic          w_tout;
    logic          w_expired;
    logic          w_restart;

    assign w_cnt_inc = r_cnt + 1'b1;
    // Enter is accepted everywhere except when it collides with clear during COLLECT.
    assign w_restart = enter_pulse && !(r_state == ST_COLLECT && clear_pulse);

`ifdef CODE_ENTRY_TIMEOUT_EN
    entry_timeout_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .run     (r_state == ST_COLLECT),
        .restart (w_restart),
        .expired (w_expired)
    );
`else
    assign w_expired = 1'b0;
`endif

    always_comb begin
        w_state_n = r_state;
        w_buf_n   = r_buf;
        w_cnt_n   = r_cnt;
        w_load    = 1'b0;
        w_tout    = 1'b0;
        case (r_state)
            ST_IDLE, ST_PRESENT: begin
                if (enter_pulse) begin
                    w_buf_n = BW'(digit_in);
                    w_cnt_n = CW'(1);
                    if (DIGITS == 1) begin
                        w_state_n = ST_PRESENT;
                        w_load    = 1'b1;
                    end else begin
                        w_state_n = ST_COLLECT;
                    end
                end else begin
                    w_cnt_n   = '0;
                    w_state_n = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (clear_pulse) begin
                    w_buf_n   = '0;
                    w_cnt_n   = '0;
                    w_state_n = ST_IDLE;
                end else if (enter_pulse) begin
                    w_buf_n = (r_buf << DIGIT_W) | BW'(digit_in);
                    w_cnt_n = w_cnt_inc;
                    if (w_cnt_inc == CW'(DIGITS)) begin
                        w_state_n = ST_PRESENT;
                        w_load    = 1'b1;
                    end
                end else if (w_expired) begin
                    w_buf_n   = '0;
                    w_cnt_n   = '0;
                    w_tout    = 1'b1;
                    w_state_n = ST_IDLE;
                end
            end
            default: begin
                w_buf_n   = '0;
                w_cnt_n   = '0;
                w_state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_buf   <= '0;
            r_cnt   <= '0;
            r_code  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_tout  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_buf   <= w_buf_n;
            r_cnt   <= w_cnt_n;
            r_valid <= (w_state_n == ST_PRESENT);
            r_busy  <= (w_state_n == ST_COLLECT);
            r_tout  <= w_tout;
            if (w_load) begin
                r_code <= w_buf_n;
            end
        end
    end

    assign code_out    = r_code;
    assign code_valid  = r_valid;
    assign digit_count = r_cnt;
    assign busy        = r_busy;
    assign timeout_err = r_tout;

endmodule

// File: tb/tb_code_entry_sequencer.sv
// Directed self-checking bench for code_entry_sequencer (DIGITS=4, DIGIT_W=4, TIMEOUT_CYC=16).
module tb_code_entry_sequencer;

    logic        clock;
    logic        reset;
    logic [3:0]  digit_in;
    logic        enter_pulse;
    logic        clear_pulse;
    logic [15:0] code_out;
    logic        code_valid;
    logic [2:0]  digit_count;
    logic        busy;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    code_entry_sequencer #(
        .DIGITS      (4),
        .DIGIT_W     (4),
        .TIMEOUT_CYC (16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .digit_in    (digit_in),
        .enter_pulse (enter_pulse),
        .clear_pulse (clear_pulse),
        .code_out    (code_out),
        .code_valid  (code_valid),
        .digit_count (digit_count),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample #1 after the capturing edge.
    task automatic drive(input logic e, input logic c, input logic [3:0] d);
        @(negedge clock);
        enter_pulse = e;
        clear_pulse = c;
        digit_in    = d;
        @(posedge clock);
        #1;
        enter_pulse = 1'b0;
        clear_pulse = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic enter(input logic [3:0] d);
        drive(1'b1, 1'b0, d);
    endtask

    initial begin
        reset       = 1'b1;
        digit_in    = '0;
        enter_pulse = 1'b0;
        clear_pulse = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_code",  {16'h0, code_out}, 32'h0);
        check("rst_valid", {31'h0, code_valid}, 32'h0);
        check("rst_count", {29'h0, digit_count}, 32'h0);
        check("rst_busy",  {31'h0, busy}, 32'h0);
        check("rst_tout",  {31'h0, timeout_err}, 32'h0);
        @(negedge clock);
        reset = 1'b0;

        // 1: full entry 3,7,1,C
        enter(4'h3);
        check("t1_cnt1", {29'h0, digit_count}, 32'd1);
        check("t1_busy1", {31'h0, busy}, 32'd1);
        enter(4'h7);
        enter(4'h1);
        check("t1_cnt3", {29'h0, digit_count}, 32'd3);
        check("t1_valid3", {31'h0, code_valid}, 32'd0);
        enter(4'hC);
        check("t1_valid", {31'h0, code_valid}, 32'd1);
        check("t1_code", {16'h0, code_out}, 32'h371C);
        check("t1_cnt4", {29'h0, digit_count}, 32'd4);
        check("t1_busy", {31'h0, busy}, 32'd0);
        tick();
        check("t1_valid_off", {31'h0, code_valid}, 32'd0);
        check("t1_cnt0", {29'h0, digit_count}, 32'd0);
        check("t1_code_hold", {16'h0, code_out}, 32'h371C);

        // 2: abandon via clear
        enter(4'h5);
        enter(4'h6);
        check("t2_cnt2", {29'h0, digit_count}, 32'd2);
        drive(1'b0, 1'b1, 4'h0);
        check("t2_cnt0", {29'h0, digit_count}, 32'd0);
        check("t2_busy", {31'h0, busy}, 32'd0);
        check("t2_valid", {31'h0, code_valid}, 32'd0);
        check("t2_code", {16'h0, code_out}, 32'h371C);

        // 3: inactivity timeout
        enter(4'h9);
        repeat (15) tick();
        check("t3_tout_early", {31'h0, timeout_err}, 32'd0);
        check("t3_cnt_early", {29'h0, digit_count}, 32'd1);
        tick();
`ifdef CODE_ENTRY_TIMEOUT_EN
        check("t3_tout", {31'h0, timeout_err}, 32'd1);
        check("t3_cnt0", {29'h0, digit_count}, 32'd0);
        check("t3_busy", {31'h0, busy}, 32'd0);
        tick();
        check("t3_tout_off", {31'h0, timeout_err}, 32'd0);
`else
        check("t3_tout", {31'h0, timeout_err}, 32'd0);
        check("t3_cnt1", {29'h0, digit_count}, 32'd1);
        check("t3_busy", {31'h0, busy}, 32'd1);
        drive(1'b0, 1'b1, 4'h0);
        check("t3_cleared", {29'h0, digit_count}, 32'd0);
`endif
        check("t3_code", {16'h0, code_out}, 32'h371C);

        // 4: enter+clear together in COLLECT
        enter(4'h1);
        drive(1'b1, 1'b1, 4'h7);
        check("t4_cnt0", {29'h0, digit_count}, 32'd0);
        check("t4_busy", {31'h0, busy}, 32'd0);
        enter(4'h8);
        enter(4'h4);
        enter(4'h2);
        enter(4'h1);
        check("t4_valid", {31'h0, code_valid}, 32'd1);
        check("t4_code", {16'h0, code_out}, 32'h8421);

        // 5: new entry started in PRESENT cycle
        enter(4'h1);
        enter(4'h2);
        enter(4'h3);
        enter(4'h4);
        check("t5_code1", {16'h0, code_out}, 32'h1234);
        enter(4'h2);
        check("t5_cnt1", {29'h0, digit_count}, 32'd1);
        check("t5_busy", {31'h0, busy}, 32'd1);
        check("t5_valid_off", {31'h0, code_valid}, 32'd0);
        enter(4'hA);
        enter(4'hB);
        enter(4'hC);
        check("t5_valid", {31'h0, code_valid}, 32'd1);
        check("t5_code2", {16'h0, code_out}, 32'h2ABC);

        // 6: asynchronous reset mid-entry
        enter(4'h5);
        enter(4'h5);
        #2;
        reset = 1'b1;
        #1;
        check("t6_code", {16'h0, code_out}, 32'h0);
        check("t6_cnt", {29'h0, digit_count}, 32'd0);
        check("t6_busy", {31'h0, busy}, 32'd0);
        check("t6_valid", {31'h0, code_valid}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        enter(4'hF);
        enter(4'h0);
        enter(4'h0);
        enter(4'hD);
        check("t6_valid_new", {31'h0, code_valid}, 32'd1);
        check("t6_code_new", {16'h0, code_out}, 32'hF00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
